// File: rtl/nn_layer_sequencer.sv
// Phase controller for the two-layer NN coprocessor: sequences MUL1 -> SIG -> MUL2 -> OUT,
// steers the shared RES/SIG RAM ports, enforces a per-stage timeout and records run latency.
module nn_layer_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] run_cycles,
  output logic             Start_Multiply1,
  input  logic             End_Multiply1,
  output logic             Start_Sigmoid,
  input  logic             End_Sigmoid,
  output logic             Start_Multiply2,
  input  logic             End_Multiply2,
  output logic             Start_Output,
  input  logic             End_Output,
  output logic             res_port_sel,
  output logic             sig_port_sel
);

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_MUL1 = 6'b000010,
    S_SIG  = 6'b000100,
    S_MUL2 = 6'b001000,
    S_OUT  = 6'b010000,
    S_ERR  = 6'b100000
  } state_t;

  localparam int              TO_W1    = TO_W + 1;
  localparam logic [TO_W:0]   TO_LIMIT = TO_W1'(TIMEOUT_CYCLES);
  localparam logic            TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W:0]   TO_ONE   = {{TO_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           state_next_s;
  logic [TO_W-1:0]  to_r;
  logic [TO_W:0]    to_inc_s;
  logic             timeout_hit_s;
  logic             in_stage_s;
  logic             go_accept_s;
  logic             run_done_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_sat_inc_s;

  logic             busy_r;
  logic             done_r;
  logic             error_r;
  logic [CNT_W-1:0] run_cycles_r;
  logic             start_mul1_r;
  logic             start_sig_r;
  logic             start_mul2_r;
  logic             start_out_r;
  logic             res_sel_r;
  logic             sig_sel_r;

  // Stage exit: the stage's own End wins over a simultaneous timeout.
  function automatic state_t stage_advance(input logic end_i, input logic hit_i,
                                           input state_t nxt_i, input state_t cur_i);
    state_t res;
    if (end_i) begin
      res = nxt_i;
    end else if (hit_i) begin
      res = S_ERR;
    end else begin
      res = cur_i;
    end
    return res;
  endfunction

  assign in_stage_s    = (state_r == S_MUL1) || (state_r == S_SIG) ||
                         (state_r == S_MUL2) || (state_r == S_OUT);
  assign to_inc_s      = {1'b0, to_r} + TO_ONE;
  assign timeout_hit_s = TO_EN && (to_inc_s == TO_LIMIT);
  assign cnt_sat_inc_s = (cnt_r == CNT_MAX) ? CNT_MAX : (cnt_r + CNT_ONE);

  // Next-state decode; End inputs of non-active stages are never looked at.
  always_comb begin
    state_next_s = state_r;
    go_accept_s  = 1'b0;
    run_done_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (go) begin
          state_next_s = S_MUL1;
          go_accept_s  = 1'b1;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_MUL1: state_next_s = stage_advance(End_Multiply1, timeout_hit_s, S_SIG, S_MUL1);
      S_SIG:  state_next_s = stage_advance(End_Sigmoid, timeout_hit_s, S_MUL2, S_SIG);
      S_MUL2: state_next_s = stage_advance(End_Multiply2, timeout_hit_s, S_OUT, S_MUL2);
      S_OUT: begin
        if (End_Output) begin
          state_next_s = S_IDLE;
          run_done_s   = 1'b1;
        end else if (timeout_hit_s) begin
          state_next_s = S_ERR;
        end else begin
          state_next_s = S_OUT;
        end
      end
      S_ERR:   state_next_s = S_ERR;
      default: state_next_s = S_ERR;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Stage timeout counter: cleared on every stage entry and outside stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_r <= {TO_W{1'b0}};
    end else if ((state_next_s != state_r) || !in_stage_s) begin
      to_r <= {TO_W{1'b0}};
    end else begin
      to_r <= to_inc_s[TO_W-1:0];
    end
  end

  // Run counter (saturating) and latched latency of the last completed run.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= {CNT_W{1'b0}};
      run_cycles_r <= {CNT_W{1'b0}};
    end else begin
      if (go_accept_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (in_stage_s) begin
        cnt_r <= cnt_sat_inc_s;
      end else begin
        cnt_r <= cnt_r;
      end
      if (run_done_s) begin
        run_cycles_r <= cnt_sat_inc_s;
      end else begin
        run_cycles_r <= run_cycles_r;
      end
    end
  end

  // Registered outputs decoded from the next state, so Starts and sels move on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      start_mul1_r <= 1'b0;
      start_sig_r  <= 1'b0;
      start_mul2_r <= 1'b0;
      start_out_r  <= 1'b0;
      res_sel_r    <= 1'b0;
      sig_sel_r    <= 1'b0;
    end else begin
      busy_r       <= (state_next_s != S_IDLE);
      done_r       <= run_done_s;
      error_r      <= (state_next_s == S_ERR);
      start_mul1_r <= (state_next_s == S_MUL1);
      start_sig_r  <= (state_next_s == S_SIG);
      start_mul2_r <= (state_next_s == S_MUL2);
      start_out_r  <= (state_next_s == S_OUT);
      res_sel_r    <= (state_next_s == S_SIG);
      sig_sel_r    <= (state_next_s == S_MUL2);
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign error           = error_r;
  assign run_cycles      = run_cycles_r;
  assign Start_Multiply1 = start_mul1_r;
  assign Start_Sigmoid   = start_sig_r;
  assign Start_Multiply2 = start_mul2_r;
  assign Start_Output    = start_out_r;
  assign res_port_sel    = res_sel_r;
  assign sig_port_sel    = sig_sel_r;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: instance A (timeout 8) for sequencing and timeout,
// instance B (CNT_W=4, timeout disabled) for run-counter saturation.
module tb_nn_layer_sequencer;
  logic        clk;
  logic        rst;
  logic        go_a, go_b;
  logic [3:0]  end_a, end_b, st_a, st_b;
  logic        busy_a, done_a, err_a, res_a, sig_a;
  logic        busy_b, done_b, err_b, res_b, sig_b;
  logic [15:0] rc_a;
  logic [3:0]  rc_b;
  int          n_checks;
  int          n_fail;

  nn_layer_sequencer #(.TIMEOUT_CYCLES(8), .TO_W(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .go(go_a), .busy(busy_a), .done(done_a), .error(err_a),
    .run_cycles(rc_a),
    .Start_Multiply1(st_a[0]), .End_Multiply1(end_a[0]),
    .Start_Sigmoid(st_a[1]),   .End_Sigmoid(end_a[1]),
    .Start_Multiply2(st_a[2]), .End_Multiply2(end_a[2]),
    .Start_Output(st_a[3]),    .End_Output(end_a[3]),
    .res_port_sel(res_a), .sig_port_sel(sig_a)
  );

  nn_layer_sequencer #(.TIMEOUT_CYCLES(0), .TO_W(13), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .go(go_b), .busy(busy_b), .done(done_b), .error(err_b),
    .run_cycles(rc_b),
    .Start_Multiply1(st_b[0]), .End_Multiply1(end_b[0]),
    .Start_Sigmoid(st_b[1]),   .End_Sigmoid(end_b[1]),
    .Start_Multiply2(st_b[2]), .End_Multiply2(end_b[2]),
    .Start_Output(st_b[3]),    .End_Output(end_b[3]),
    .res_port_sel(res_b), .sig_port_sel(sig_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {Starts[3:0], res_sel, sig_sel, busy, done, error}
  function automatic logic [8:0] vec_a();
    return {st_a, res_a, sig_a, busy_a, done_a, err_a};
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (vec_a() !== 9'b000000000) begin
      n_fail++; $display("FAIL reset_outputs_a: got %b expected %b", vec_a(), 9'b000000000);
    end
    n_checks++;
    if (rc_a !== 16'd0) begin
      n_fail++; $display("FAIL reset_run_cycles_a: got %0d expected 0", rc_a);
    end
    n_checks++;
    if ({st_b, busy_b, err_b, rc_b} !== 10'd0) begin
      n_fail++; $display("FAIL reset_outputs_b: got %b expected 0", {st_b, busy_b, err_b, rc_b});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Run on instance A; stage k ends after lat_k cycles of Start (End in cycle lat_k+1), -1 = never.
  task automatic run_a(input int l0, input int l1, input int l2, input int l3,
                       input bit stray, input logic [15:0] exp_rc, input string tag);
    int lat [4];
    int stage, scnt, guard;
    logic [3:0] one;
    logic [8:0] exp_v;
    bit fire;
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    one = 4'b0001;
    go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    stage = 0; scnt = 1; guard = 0;
    while (stage < 4 && guard < 200) begin
      exp_v = {one << stage, stage == 1, stage == 2, 1'b1, 1'b0, 1'b0};
      n_checks++;
      if (vec_a() !== exp_v) begin
        n_fail++;
        $display("FAIL %s stage%0d cyc%0d: got %b expected %b", tag, stage, scnt, vec_a(), exp_v);
      end
      fire = (lat[stage] >= 0) && (scnt == lat[stage] + 1);
      end_a = 4'b0000;
      if (fire) end_a[stage] = 1'b1;
      if (stray && stage == 0 && scnt == 2) end_a[1] = 1'b1;
      if (stray && stage == 1 && scnt == 2) go_a = 1'b1;
      @(negedge clk);
      end_a = 4'b0000;
      go_a  = 1'b0;
      if (fire) begin
        stage++; scnt = 1;
      end else if (scnt == 8) begin
        stage = 5;
      end else begin
        scnt++;
      end
      guard++;
    end
    if (guard >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL %s cycle budget expired: got stage %0d expected completion", tag, stage);
    end else if (stage == 4) begin
      n_checks++;
      if (vec_a() !== 9'b000000010) begin
        n_fail++; $display("FAIL %s done_cycle: got %b expected %b", tag, vec_a(), 9'b000000010);
      end
      n_checks++;
      if (rc_a !== exp_rc) begin
        n_fail++; $display("FAIL %s run_cycles: got %0d expected %0d", tag, rc_a, exp_rc);
      end
      @(negedge clk);
      n_checks++;
      if (vec_a() !== 9'b000000000) begin
        n_fail++; $display("FAIL %s idle_after_done: got %b expected %b", tag, vec_a(), 9'b000000000);
      end
      n_checks++;
      if (rc_a !== exp_rc) begin
        n_fail++; $display("FAIL %s run_cycles_hold: got %0d expected %0d", tag, rc_a, exp_rc);
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (vec_a() !== 9'b000000101) begin
          n_fail++; $display("FAIL %s err_state%0d: got %b expected %b", tag, i, vec_a(), 9'b000000101);
        end
        end_a = 4'b1111;
        go_a  = 1'b1;
        @(negedge clk);
        end_a = 4'b0000;
        go_a  = 1'b0;
      end
    end
  endtask

  task automatic test_nominal();
    run_a(5, 3, 5, 2, 1'b0, 16'd19, "nominal");
  endtask

  task automatic test_back_to_back();
    run_a(1, 1, 1, 1, 1'b0, 16'd8, "b2b_first");
    run_a(2, 0, 3, 0, 1'b0, 16'd9, "b2b_second");
  endtask

  task automatic test_stray();
    run_a(5, 3, 5, 2, 1'b1, 16'd19, "stray");
  endtask

  task automatic test_timeout();
    run_a(5, 3, -1, 2, 1'b0, 16'd0, "timeout");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (vec_a() !== 9'b000000000) begin
      n_fail++; $display("FAIL timeout_recover: got %b expected %b", vec_a(), 9'b000000000);
    end
    run_a(5, 3, 5, 2, 1'b0, 16'd19, "after_err");
  endtask

  task automatic test_collision();
    run_a(5, 7, 5, 2, 1'b0, 16'd23, "collision");
  endtask

  task automatic test_reset_mid_sig();
    go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    repeat (5) @(negedge clk);
    end_a[0] = 1'b1;
    @(negedge clk);
    end_a = 4'b0000;
    n_checks++;
    if (vec_a() !== 9'b001010100) begin
      n_fail++; $display("FAIL midsig_in_sig: got %b expected %b", vec_a(), 9'b001010100);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (vec_a() !== 9'b000000000) begin
      n_fail++; $display("FAIL midsig_reset_outputs: got %b expected %b", vec_a(), 9'b000000000);
    end
    n_checks++;
    if (rc_a !== 16'd0) begin
      n_fail++; $display("FAIL midsig_reset_run_cycles: got %0d expected 0", rc_a);
    end
    run_a(5, 3, 5, 2, 1'b0, 16'd19, "after_midsig");
  endtask

  // Instance B: each stage ends after w cycles of Start; 4*(w+1) cycles, saturating at 15.
  task automatic run_b(input int w, input logic [3:0] exp_rc, input string tag);
    logic [3:0] one;
    one = 4'b0001;
    go_b = 1'b1;
    @(negedge clk);
    go_b = 1'b0;
    for (int s = 0; s < 4; s++) begin
      n_checks++;
      if (st_b !== (one << s)) begin
        n_fail++; $display("FAIL %s start%0d: got %b expected %b", tag, s, st_b, one << s);
      end
      repeat (w) @(negedge clk);
      end_b[s] = 1'b1;
      @(negedge clk);
      end_b = 4'b0000;
    end
    n_checks++;
    if ({done_b, busy_b, err_b} !== 3'b100) begin
      n_fail++; $display("FAIL %s done_flags: got %b expected 100", tag, {done_b, busy_b, err_b});
    end
    n_checks++;
    if (rc_b !== exp_rc) begin
      n_fail++; $display("FAIL %s run_cycles: got %0d expected %0d", tag, rc_b, exp_rc);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    run_b(10, 4'd15, "saturate");
    run_b(1, 4'd8, "unsaturated");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    go_a  = 1'b0;
    go_b  = 1'b0;
    end_a = 4'b0000;
    end_b = 4'b0000;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_stray();
    test_timeout();
    test_collision();
    test_reset_mid_sig();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Top-level phase controller for the two-layer neural-network coprocessor. It sequences the four compute/transfer stages (layer-1 multiply, Sigmoid, layer-2 multiply, output streaming) with level-Start/pulse-End handshakes. It steers the shared RES and SIG RAM port multiplexers to the active stage, enforces a per-stage timeout, and reports the total run latency. It sits between the AXI-Stream receive logic, which loads A/B RAMs and pulses `go`, and the datapath stage modules.

## Interface
- `TIMEOUT_CYCLES`, 4096: max cycles a stage may hold Start without End; 0 disables the timeout.
- `TO_W`, 13: timeout counter width; must hold `TIMEOUT_CYCLES`.
- `CNT_W`, 16: run-cycle counter width.

All ports are sampled and driven on `clk`. There is one clock. Reset is synchronous and active-high.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `go`  in  1  input RAMs loaded; sampled only in IDLE.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse on run completion.
- `error`  out  1  sticky stage-timeout flag.
- `run_cycles`  out  CNT_W  latched cycle count of the last completed run.
- `Start_Multiply1` / `End_Multiply1`  out/in  1  layer-1 multiply handshake.
- `Start_Sigmoid` / `End_Sigmoid`  out/in  1  Sigmoid handshake.
- `Start_Multiply2` / `End_Multiply2`  out/in  1  layer-2 multiply handshake.
- `Start_Output` / `End_Output`  out/in  1  output streamer handshake.
- `res_port_sel`  out  1  RES RAM owner: 0 = Multiply1 (write), 1 = Sigmoid (read).
- `sig_port_sel`  out  1  SIG RAM owner: 0 = Sigmoid (write), 1 = Multiply2 (read).

## Operation
- States (one-hot): IDLE, MUL1, SIG, MUL2, OUT, ERR.
- Every output is registered. Reset values: all Starts 0, `busy` 0, `done` 0, `error` 0, `run_cycles` 0, both sels 0, state IDLE. Reset clears the timeout counter and the run counter.
- IDLE: `go`=1 moves to MUL1 with `Start_Multiply1`<=1 and the run counter cleared to 0.
- Stage handshake:
  - Start is held high for the whole stage.
  - While in stage X, `End_X`=1 drops `Start_X` and raises the next stage's Start on the same edge.
  - Transition order: MUL1→SIG→MUL2→OUT→IDLE.
  - On `End_Output`, the state returns to IDLE, `done`<=1 for one cycle, and `run_cycles`<=run counter+1.
- Start deassertion is fixed at the edge after End is sampled. Stage modules use an End→DONE→IDLE sequence, so they see Start low when they re-enter IDLE.
- End inputs of non-active stages are ignored in every state, including IDLE and ERR.
- `go` while busy is ignored. `go` is not queued.
- Sel steering:
  - `res_port_sel`=1 exactly while in SIG.
  - `sig_port_sel`=1 exactly while in MUL2.
  - Both sels update on the same edge as the Start that owns them.
- Timeout:
  - The timeout counter clears on every stage entry and increments each cycle in MUL1/SIG/MUL2/OUT.
  - If it reaches `TIMEOUT_CYCLES` with End still low (and `TIMEOUT_CYCLES`≠0), the state goes to ERR.
  - In ERR: all Starts 0, both sels 0, `error`=1, `busy`=1.
  - ERR is left only by `rst`.
  - If End arrives on the same cycle the counter hits the limit, End wins and there is no error.
- Run counter: increments every non-IDLE, non-ERR cycle and saturates at 2^CNT_W−1 (no wrap). `run_cycles` holds its value until the next completion or reset.

## Timing
- `go` at edge k gives `Start_Multiply1`=1 and `busy`=1 after edge k.
- Stage-to-stage turnaround: End at edge n gives the new Start after edge n, a 0-cycle gap. The Start overlap between stages is zero.
- `done` is coincident with `busy` falling. `go` in the same cycle as `done` is accepted one cycle later, since the state is already IDLE after that edge.
- `rst` mid-run: after the reset edge, all Starts are 0 and the state is IDLE. Stage modules must be reset by the same `rst`.
- `run_cycles` equals the number of cycles from MUL1 entry up to and including the `End_Output` cycle.

## Test plan
- Nominal run: stage models pulse End after 5/3/5/2 cycles of Start. The four Starts rise in order with no overlap, `res_port_sel` is high only during SIG, `sig_port_sel` is high only during MUL2, `done` pulses once, and `run_cycles`=19.
- Stray events: `End_Sigmoid` pulsed during MUL1 and `go` pulsed during SIG. Neither changes the state sequence, and the result is identical to the nominal run.
- Timeout: `TIMEOUT_CYCLES`=8, Multiply2 never ends. The state is ERR 8 cycles after `Start_Multiply2` rises, `error`=1 with all Starts 0, and the state stays there until `rst`, then returns to IDLE with `error`=0.
- End/timeout collision: `End_Sigmoid` arrives exactly on the limit cycle. The state advances to MUL2 and `error` stays 0.
- Reset mid-SIG: all outputs return to their reset values on the next edge. A following `go` yields a clean nominal run.
- Saturation: `CNT_W`=4 with long stage latencies. `run_cycles`=15.
